fft_freq_analyzer: RTL and testbench
====================================

Name: fft_freq_analyzer

Overview:
- Downstream stage of the FAS FFT datapath.
- Accepts one frame of 16 complex FFT bins as a parallel snapshot, qualified by a single-cycle valid strobe.
- Scans the bins sequentially through a 2-stage magnitude-squared pipeline and reports the index and magnitude of the strongest bin.
- Feeds the top-level freq/done outputs.

Parameters:
- DATA_WIDTH, 32, bin word width: [31:16] signed real part, [15:0] signed imaginary part.
- BIN_NUM, 16, number of bins per frame.
- BIN_ADDR_WIDTH, 4, width of the bin index (log2 of BIN_NUM).
- MAG_WIDTH, 32, width of the unsigned magnitude-squared value.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- bins_valid  input  1  frame strobe; bins_in is valid in this cycle.
- bins_in  input  BIN_NUM*DATA_WIDTH  flattened frame; bin k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- busy  output  1  high while a frame is captured or being scanned.
- done  output  1  one-cycle pulse; result registers were updated on the preceding edge.
- freq  output  BIN_ADDR_WIDTH  index of the peak bin.
- peak_mag  output  MAG_WIDTH  re*re + im*im of the peak bin.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, freq=0, peak_mag=0; frame store, pipeline and best registers all cleared.
- States and transitions:
  - IDLE: on bins_valid=1, capture all 16 bins into the frame store at edge E0 -> SCAN.
  - SCAN: issue counter idx goes 0..15, one bin per edge E1..E16; after issuing idx 15 -> FLUSH.
  - FLUSH: two edges, E17 and E18, drain the pipeline. At E18 load freq/peak_mag from the best registers, pulse done, go to IDLE.
- busy = (state != IDLE), decoded combinationally.
- done is registered: high for exactly the one cycle following E18, i.e. 18 edges after the sampling edge E0.
- Pipeline:
  - Stage 1, registered: sq_re = re*re, sq_im = im*im, both signed-by-signed, each 31 bits unsigned; the bin index travels alongside.
  - Stage 2, registered: mag = sq_re + sq_im, zero-extended to MAG_WIDTH. Maximum is 2^31, no overflow.
  - Compare: if first bin of the frame or mag > best_mag, then best_mag <= mag and best_idx <= idx.
- Ties: strict greater-than, so the lowest index wins.
- All-zero frame: freq=0, peak_mag=0.
- bins_valid while busy=1: ignored. The frame store is not disturbed and no extra done is produced.
- bins_valid in the done cycle: state is IDLE, so it is accepted. The new frame's done follows 18 edges later.
- Result hold: freq/peak_mag keep their value until the next done; they never change mid-scan.
- Reset mid-operation: the scan is aborted immediately, no done is issued, and outputs return to 0.
- bins_in is sampled only at the capture edge; it may change freely afterwards.

Decomposition:
- Shared package fas_pkg:
  - DATA_WIDTH, BIN_NUM, BIN_ADDR_WIDTH, MAG_WIDTH constants.
  - Re/im field slice positions.
  - State encoding localparams: IDLE=2'd0, SCAN=2'd1, FLUSH=2'd2.
  - log2 function.
- One sub-module, fas_mag_sq:
  - Registered squarer plus adder for one bin, 2-cycle latency, index side-band passed through.
  - The top holds the FSM, frame store, issue counter, comparator and output registers.

Test Plan:
- Single peak: all bins 0, bin 5 = {re=100, im=0}, bins_valid at E0 -> done high in the cycle after E18, freq=5, peak_mag=10000, busy low in the done cycle.
- Tie: bins 3 and 9 = {re=0, im=-200}, others {re=1, im=1} -> freq=3, peak_mag=40000.
- Extreme values: bin 15 = {re=-32768, im=-32768}, others {re=32767, im=0} -> freq=15, peak_mag=32'h8000_0000, no overflow.
- Busy ignore: frame A (peak bin 2), second bins_valid at E5 with frame B (peak bin 7) -> exactly one done, freq=2.
- Back-to-back: frame B presented in frame A's done cycle -> accepted; second done 18 edges later, freq=7. freq holds 2 throughout B's scan.
- Reset abort: assert rst=0 at E10 of a scan -> busy=0, done never pulses, freq=0, peak_mag=0; a new frame after release completes normally.

Source files
------------

// File: rtl/fas_pkg.sv
// fas_pkg: shared constants, state encoding and helpers for the FFT
// frequency analyzer (fft_freq_analyzer) and its magnitude pipeline.
//   - bin word layout: [31:16] signed real part, [15:0] signed imaginary part
//   - controller states: IDLE, SCAN, FLUSH
package fas_pkg;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int DATA_WIDTH     = 32;
    localparam int BIN_NUM        = 16;
    localparam int BIN_ADDR_WIDTH = clog2_f(BIN_NUM);
    localparam int MAG_WIDTH      = 32;
    localparam int HALF_WIDTH     = DATA_WIDTH / 2;
    // A square of a 16-bit signed value is at most 2^30, so 31 bits suffice.
    localparam int SQ_WIDTH       = 2 * HALF_WIDTH - 1;

    // Field slice positions inside a bin word.
    localparam int RE_LSB = HALF_WIDTH;
    localparam int IM_LSB = 0;

    // Controller state encoding.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_SCAN  = SCAN,
        ST_FLUSH = FLUSH
    } state_e;

endpackage

// File: rtl/fas_mag_sq.sv
// fas_mag_sq: two-stage registered magnitude-squared unit for one bin.
//   stage 1: re*re and im*im (signed x signed), index and valid carried along
//   stage 2: sum of the two squares, zero-extended to MAG_WIDTH
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   valid_i         a bin is presented this cycle
//   re_i, im_i      signed real / imaginary parts
//   idx_i           bin index side-band
//   valid_o         mag_o/idx_o hold a result this cycle
//   mag_o           re*re + im*im
//   idx_o           index matching mag_o
module fas_mag_sq
    import fas_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [HALF_WIDTH-1:0]     re_i,
    input  logic [HALF_WIDTH-1:0]     im_i,
    input  logic [BIN_ADDR_WIDTH-1:0] idx_i,
    output logic                      valid_o,
    output logic [MAG_WIDTH-1:0]      mag_o,
    output logic [BIN_ADDR_WIDTH-1:0] idx_o
);

    logic signed [SQ_WIDTH-1:0] re_x;
    logic signed [SQ_WIDTH-1:0] im_x;
    logic [SQ_WIDTH-1:0]        sq_re_d, sq_re_q;
    logic [SQ_WIDTH-1:0]        sq_im_d, sq_im_q;
    logic                       s1_valid_q;
    logic [BIN_ADDR_WIDTH-1:0]  s1_idx_q;
    logic [MAG_WIDTH-1:0]       mag_d, mag_q;
    logic                       s2_valid_q;
    logic [BIN_ADDR_WIDTH-1:0]  s2_idx_q;

    // Sign-extend to the square width; the true square is non-negative and
    // below 2^31, so the low SQ_WIDTH bits of the product are exact.
    assign re_x    = {{(SQ_WIDTH-HALF_WIDTH){re_i[HALF_WIDTH-1]}}, re_i};
    assign im_x    = {{(SQ_WIDTH-HALF_WIDTH){im_i[HALF_WIDTH-1]}}, im_i};
    assign sq_re_d = SQ_WIDTH'(re_x * re_x);
    assign sq_im_d = SQ_WIDTH'(im_x * im_x);
    assign mag_d   = MAG_WIDTH'(sq_re_q) + MAG_WIDTH'(sq_im_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sq_re_q    <= '0;
            sq_im_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            mag_q      <= '0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
        end else begin
            sq_re_q    <= sq_re_d;
            sq_im_q    <= sq_im_d;
            s1_valid_q <= valid_i;
            s1_idx_q   <= idx_i;
            mag_q      <= mag_d;
            s2_valid_q <= s1_valid_q;
            s2_idx_q   <= s1_idx_q;
        end
    end

    assign valid_o = s2_valid_q;
    assign mag_o   = mag_q;
    assign idx_o   = s2_idx_q;

endmodule

// File: rtl/fft_freq_analyzer.sv
// fft_freq_analyzer: captures a frame of BIN_NUM complex FFT bins, scans
// them one per cycle through fas_mag_sq and reports the strongest bin.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   bins_valid  frame strobe; bins_in is sampled when the block is idle
//   bins_in     flattened frame, bin k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy        high while a frame is held or being scanned
//   done        one-cycle pulse, freq/peak_mag updated on the previous edge
//   freq        index of the peak bin (lowest index wins ties)
//   peak_mag    re*re + im*im of the peak bin
//   state_dbg   current controller state, for observation only
// Handshake: bins_valid is a single-cycle strobe with no back-pressure; a
// strobe is taken only when busy is low, otherwise it is dropped.
module fft_freq_analyzer
    import fas_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bins_valid,
    input  logic [BIN_NUM*DATA_WIDTH-1:0] bins_in,
    output logic                          busy,
    output logic                          done,
    output logic [BIN_ADDR_WIDTH-1:0]     freq,
    output logic [MAG_WIDTH-1:0]          peak_mag,
    output logic [1:0]                    state_dbg
);

    state_e                    state_q, state_d;
    logic [DATA_WIDTH-1:0]     frame_q [BIN_NUM];
    logic [BIN_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                      flush_q, flush_d;
    logic                      done_q, done_d;
    logic                      capture;
    logic                      issue;
    logic                      load_result;

    logic [DATA_WIDTH-1:0]     cur_bin;
    logic                      s2_valid;
    logic [MAG_WIDTH-1:0]      s2_mag;
    logic [BIN_ADDR_WIDTH-1:0] s2_idx;

    logic                      take;
    logic [MAG_WIDTH-1:0]      best_mag_q, best_mag_d;
    logic [BIN_ADDR_WIDTH-1:0] best_idx_q, best_idx_d;
    logic [BIN_ADDR_WIDTH-1:0] freq_q;
    logic [MAG_WIDTH-1:0]      peak_q;

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            flush_q <= flush_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        flush_d     = flush_q;
        done_d      = 1'b0;
        capture     = 1'b0;
        issue       = 1'b0;
        load_result = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d   = '0;
                flush_d = 1'b0;
                if (bins_valid) begin
                    capture = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                issue = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == BIN_ADDR_WIDTH'(BIN_NUM - 1)) begin
                    state_d = ST_FLUSH;
                    flush_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                // Second flush edge: the last bin leaves stage 2 now, so the
                // result is taken from the compare's next-value path.
                if (flush_q) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    load_result = 1'b1;
                end else begin
                    flush_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign state_dbg = state_q;

    // ---------------- frame store ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < BIN_NUM; k++) begin
                frame_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < BIN_NUM; k++) begin
                frame_q[k] <= bins_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign cur_bin = frame_q[idx_q];

    // ---------------- magnitude pipeline ----------------
    fas_mag_sq u_mag_sq (
        .clk     (clk),
        .rst     (rst),
        .valid_i (issue),
        .re_i    (cur_bin[RE_LSB +: HALF_WIDTH]),
        .im_i    (cur_bin[IM_LSB +: HALF_WIDTH]),
        .idx_i   (idx_q),
        .valid_o (s2_valid),
        .mag_o   (s2_mag),
        .idx_o   (s2_idx)
    );

    // ---------------- peak tracking ----------------
    // Bin 0 always seeds the search; afterwards strict greater-than keeps the
    // lowest index on ties.
    always_comb begin
        take       = s2_valid && ((s2_idx == '0) || (s2_mag > best_mag_q));
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        if (take) begin
            best_mag_d = s2_mag;
            best_idx_d = s2_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_mag_q <= '0;
            best_idx_q <= '0;
            freq_q     <= '0;
            peak_q     <= '0;
        end else begin
            best_mag_q <= best_mag_d;
            best_idx_q <= best_idx_d;
            if (load_result) begin
                freq_q <= best_idx_d;
                peak_q <= best_mag_d;
            end
        end
    end

    assign freq     = freq_q;
    assign peak_mag = peak_q;

endmodule

// File: tb/tb_fft_freq_analyzer.sv
// tb_fft_freq_analyzer: randomized and directed frames against a
// behavioural peak-search model; a monitor pops expected results when done
// pulses and checks that results hold steady between pulses.
module tb_fft_freq_analyzer;
    import fas_pkg::*;

    localparam int NB = BIN_NUM;

    // ---------------- clock / reset ----------------
    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      bins_valid = 1'b0;
    logic [NB*DATA_WIDTH-1:0]  bins_in = '0;
    logic                      busy;
    logic                      done;
    logic [BIN_ADDR_WIDTH-1:0] freq;
    logic [MAG_WIDTH-1:0]      peak_mag;
    logic [1:0]                state_dbg;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft_freq_analyzer dut (
        .clk        (clk),
        .rst        (rst),
        .bins_valid (bins_valid),
        .bins_in    (bins_in),
        .busy       (busy),
        .done       (done),
        .freq       (freq),
        .peak_mag   (peak_mag),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int passed = 0;
    int total  = 0;
    logic [BIN_ADDR_WIDTH+MAG_WIDTH-1:0] exp_q[$];
    int                                  exp_cyc_q[$];
    logic [BIN_ADDR_WIDTH-1:0]           held_f = '0;
    logic [MAG_WIDTH-1:0]                held_m = '0;

    logic signed [15:0] fre [NB];
    logic signed [15:0] fim [NB];

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [BIN_ADDR_WIDTH+MAG_WIDTH-1:0] ref_result();
        longint best = -1;
        int     bi   = 0;
        for (int k = 0; k < NB; k++) begin
            longint m = longint'(fre[k]) * longint'(fre[k]) + longint'(fim[k]) * longint'(fim[k]);
            if (m > best) begin
                best = m;
                bi   = k;
            end
        end
        return {BIN_ADDR_WIDTH'(bi), MAG_WIDTH'(best)};
    endfunction

    function automatic logic [NB*DATA_WIDTH-1:0] pack_frame();
        logic [NB*DATA_WIDTH-1:0] v;
        for (int k = 0; k < NB; k++) v[k*DATA_WIDTH +: DATA_WIDTH] = {fre[k], fim[k]};
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fill(input int re, input int im);
        for (int k = 0; k < NB; k++) begin
            fre[k] = 16'(re);
            fim[k] = 16'(im);
        end
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic send_frame(input bit accept);
        int cap;
        if (!accept) check("busy_when_ignored", busy, 1);
        bins_in    = pack_frame();
        bins_valid = 1'b1;
        @(posedge clk);
        #1;
        cap = cyc;
        if (accept) begin
            exp_q.push_back(ref_result());
            exp_cyc_q.push_back(cap + 18);
        end
        @(negedge clk);
        bins_valid = 1'b0;
        bins_in    = {NB{$urandom}};
        if (accept) check("busy_after_capture", busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) check("idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                check("busy_in_done_cycle", busy, 0);
                if (exp_q.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    logic [BIN_ADDR_WIDTH+MAG_WIDTH-1:0] e;
                    int c;
                    e = exp_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    check("done_latency", cyc, c);
                    check("freq", freq, e[MAG_WIDTH +: BIN_ADDR_WIDTH]);
                    check("peak_mag", peak_mag, e[MAG_WIDTH-1:0]);
                    held_f = e[MAG_WIDTH +: BIN_ADDR_WIDTH];
                    held_m = e[MAG_WIDTH-1:0];
                end
            end else begin
                check("freq_hold", freq, held_f);
                check("peak_mag_hold", peak_mag, held_m);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_freq", freq, 0);
        check("reset_peak_mag", peak_mag, 0);
        check("reset_state", state_dbg, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single peak at bin 5.
        fill(0, 0);
        fre[5] = 16'sd100;
        send_frame(1);
        wait_idle();

        // Tie between bins 3 and 9: lowest index wins.
        fill(1, 1);
        fre[3] = 16'sd0; fim[3] = -16'sd200;
        fre[9] = 16'sd0; fim[9] = -16'sd200;
        send_frame(1);
        wait_idle();

        // Extreme values: 2^31 must not overflow.
        fill(32767, 0);
        fre[15] = -16'sd32768;
        fim[15] = -16'sd32768;
        send_frame(1);
        wait_idle();

        // Strobe while busy is dropped.
        fill(0, 0);
        fre[2] = 16'sd50;
        send_frame(1);
        repeat (4) @(negedge clk);
        fill(0, 0);
        fre[7] = 16'sd90;
        send_frame(0);
        wait_idle();

        // Back-to-back: frame B presented in frame A's done cycle.
        fill(0, 0);
        fre[2] = 16'sd50;
        send_frame(1);
        repeat (18) @(negedge clk);
        check("done_cycle_for_b2b", done, 1);
        fill(0, 0);
        fre[7] = 16'sd90;
        send_frame(1);
        wait_idle();

        // Reset mid-scan aborts without a done.
        for (int k = 0; k < NB; k++) begin
            fre[k] = 16'($urandom);
            fim[k] = 16'($urandom);
        end
        send_frame(1);
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_freq", freq, 0);
        check("abort_peak_mag", peak_mag, 0);
        exp_q.delete();
        exp_cyc_q.delete();
        held_f = '0;
        held_m = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (25) @(negedge clk);
        fill(0, 0);
        fre[11] = 16'sd7; fim[11] = -16'sd3;
        send_frame(1);
        wait_idle();

        // Randomized frames.
        for (int t = 0; t < 24; t++) begin
            int mode;
            mode = int'($urandom_range(0, 3));
            for (int k = 0; k < NB; k++) begin
                case (mode)
                    0: begin
                        fre[k] = 16'($urandom);
                        fim[k] = 16'($urandom);
                    end
                    1: begin
                        fre[k] = 16'(int'($urandom_range(0, 6)) - 3);
                        fim[k] = 16'(int'($urandom_range(0, 6)) - 3);
                    end
                    2: begin
                        fre[k] = 16'sd0;
                        fim[k] = 16'sd0;
                    end
                    default: begin
                        fre[k] = ($urandom_range(0, 1) == 1) ? -16'sd32768 : 16'($urandom);
                        fim[k] = ($urandom_range(0, 1) == 1) ? 16'sd32767 : 16'($urandom);
                    end
                endcase
            end
            send_frame(1);
            wait_idle();
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
